// File: rtl/seq_pkg.sv
// Shared types and constants for the hardwired instruction sequencer and its
// companion control blocks: T-state encoding, opcode classes, IR field layout.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    typedef enum logic [1:0] {
        CLS_RRR, CLS_HILO, CLS_RR, CLS_ILL
    } cls_t;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: IR contents to opcode class and ALU function.
// Unsupported opcodes map to CLS_ILL with alu_op forced to 0.
module seq_decode
    import seq_pkg::*;
(
    input  logic [31:0] ir,
    output cls_t        cls,
    output logic [4:0]  alu_op
);

    logic [4:0]  opcode;
    logic [26:0] unused_fields;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    // Register selects are decoded in the DataPath; only the opcode matters here.
    assign unused_fields = {ir[RA_MSB:RA_LSB], ir[RB_MSB:RB_LSB],
                            ir[RC_MSB:RC_LSB], ir[RC_LSB-1:0]};

    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_RRR;
            OP_MUL, OP_DIV:                  cls = CLS_HILO;
            OP_NEG, OP_NOT:                  cls = CLS_RR;
            default:                         cls = CLS_ILL;
        endcase
    end

    assign alu_op = (cls == CLS_ILL) ? 5'd0 : opcode;

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer for register-format ALU instructions.
// Define SEQ_MEM_WAIT_EN to make T1 stall until mem_ready.
module alu_sequencer
    import seq_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        z_in,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        pc_in,
    output logic        read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t     state, state_nxt;
    cls_t       cls;
    logic [4:0] dec_op;
    logic       t1_exit;

    seq_decode u_decode (
        .ir     (ir),
        .cls    (cls),
        .alu_op (dec_op)
    );

`ifdef SEQ_MEM_WAIT_EN
    assign t1_exit = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign t1_exit = 1'b1;
`endif

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    // The final T-state doubles as the instruction boundary, so a held start
    // chains straight into the next fetch without an IDLE gap.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   if (t1_exit) state_nxt = T2;
            T2:   state_nxt = T3;
            T3:   state_nxt = (cls == CLS_ILL) ? IDLE : T4;
            T4:   if (cls == CLS_RR)        state_nxt = start ? T0 : IDLE;
                  else                      state_nxt = T5;
            T5:   if (cls == CLS_HILO)      state_nxt = T6;
                  else if (cls == CLS_RRR)  state_nxt = start ? T0 : IDLE;
                  else                      state_nxt = IDLE;
            T6:   state_nxt = start ? T0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        {pc_out, mar_in, inc_pc, z_in, zlo_out, zhi_out, pc_in, read, mdr_in,
         mdr_out, ir_in, y_in, hi_in, lo_in, gra, grb, grc, r_in, r_out,
         done, illegal} = '0;
        alu_op = 5'd0;
        busy   = (state != IDLE);
        case (state)
            T0: {pc_out, mar_in, inc_pc, z_in} = 4'b1111;
            T1: begin
                read    = 1'b1;
                mdr_in  = 1'b1;
                zlo_out = t1_exit;
                pc_in   = t1_exit;
            end
            T2: {mdr_out, ir_in} = 2'b11;
            T3: begin
                if (cls == CLS_ILL) begin
                    illegal = 1'b1;
                end else begin
                    grb   = 1'b1;
                    r_out = 1'b1;
                    if (cls == CLS_RR) begin
                        z_in   = 1'b1;
                        alu_op = dec_op;
                    end else begin
                        y_in = 1'b1;
                    end
                end
            end
            T4: begin
                if (cls == CLS_RR) begin
                    {zlo_out, gra, r_in, done} = 4'b1111;
                end else if (cls != CLS_ILL) begin
                    {grc, r_out, z_in} = 3'b111;
                    alu_op = dec_op;
                end
            end
            T5: begin
                if (cls == CLS_RRR)       {zlo_out, gra, r_in, done} = 4'b1111;
                else if (cls == CLS_HILO) {zlo_out, lo_in} = 2'b11;
            end
            T6: {zhi_out, hi_in, done} = 3'b111;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a per-cycle expected-strobe queue built
// from the instruction tables, plus hand-computed latency and literal checks.
module tb_alu_sequencer;

    logic        clock, clear, start, mem_ready;
    logic [31:0] ir;
    logic pc_out, mar_in, inc_pc, z_in, zlo_out, zhi_out, pc_in, read, mdr_in;
    logic mdr_out, ir_in, y_in, hi_in, lo_in, gra, grb, grc, r_in, r_out;
    logic [4:0] alu_op;
    logic busy, done, illegal;

    alu_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .pc_in(pc_in), .read(read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .gra(gra), .grb(grb), .grc(grc),
        .r_in(r_in), .r_out(r_out), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit positions of each strobe in the packed observation word.
    localparam logic [26:0] PC_OUT  = 27'd1 << 26;
    localparam logic [26:0] MAR_IN  = 27'd1 << 25;
    localparam logic [26:0] INC_PC  = 27'd1 << 24;
    localparam logic [26:0] Z_IN    = 27'd1 << 23;
    localparam logic [26:0] ZLO_OUT = 27'd1 << 22;
    localparam logic [26:0] ZHI_OUT = 27'd1 << 21;
    localparam logic [26:0] PC_IN   = 27'd1 << 20;
    localparam logic [26:0] READ    = 27'd1 << 19;
    localparam logic [26:0] MDR_IN  = 27'd1 << 18;
    localparam logic [26:0] MDR_OUT = 27'd1 << 17;
    localparam logic [26:0] IR_IN   = 27'd1 << 16;
    localparam logic [26:0] Y_IN    = 27'd1 << 15;
    localparam logic [26:0] HI_IN   = 27'd1 << 14;
    localparam logic [26:0] LO_IN   = 27'd1 << 13;
    localparam logic [26:0] GRA     = 27'd1 << 12;
    localparam logic [26:0] GRB     = 27'd1 << 11;
    localparam logic [26:0] GRC     = 27'd1 << 10;
    localparam logic [26:0] R_IN    = 27'd1 << 9;
    localparam logic [26:0] R_OUT   = 27'd1 << 8;
    localparam logic [26:0] BUSY    = 27'd1 << 7;
    localparam logic [26:0] DONE    = 27'd1 << 6;
    localparam logic [26:0] ILLEGAL = 27'd1 << 5;

    localparam logic [31:0] IR_ADD = 32'h1891_8000;
    localparam logic [31:0] IR_MUL = 32'h781A_0000;
    localparam logic [31:0] IR_NOT = 32'h92B0_0000;
    localparam logic [31:0] IR_ILL = 32'hF800_0000;
    localparam logic [31:0] IR_SHL = 32'h5891_8000;
    localparam logic [31:0] IR_DIV = 32'h8091_8000;
    localparam logic [31:0] IR_NEG = 32'h8891_8000;

    int n_total = 0;
    int n_pass  = 0;
    int pc_in_cnt = 0;
    logic [26:0] exp_q[$];
    logic [26:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [26:0] observe();
        return {pc_out, mar_in, inc_pc, z_in, zlo_out, zhi_out, pc_in, read, mdr_in,
                mdr_out, ir_in, y_in, hi_in, lo_in, gra, grb, grc, r_in, r_out,
                busy, done, illegal, alu_op};
    endfunction

    // Expected per-cycle strobes for one instruction, T0 through its last T-state.
    task automatic model_instr(input logic [31:0] i, input int waits);
        logic [4:0] op;
        logic [26:0] op_w;
        op   = i[31:27];
        op_w = {22'd0, op};
        exp_q.push_back(PC_OUT | MAR_IN | INC_PC | Z_IN | BUSY);
        for (int k = 0; k < waits; k++) exp_q.push_back(READ | MDR_IN | BUSY);
        exp_q.push_back(READ | MDR_IN | ZLO_OUT | PC_IN | BUSY);
        exp_q.push_back(MDR_OUT | IR_IN | BUSY);
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(GRB | R_OUT | Y_IN | BUSY);
            exp_q.push_back(GRC | R_OUT | Z_IN | BUSY | op_w);
            exp_q.push_back(ZLO_OUT | GRA | R_IN | DONE | BUSY);
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(GRB | R_OUT | Y_IN | BUSY);
            exp_q.push_back(GRC | R_OUT | Z_IN | BUSY | op_w);
            exp_q.push_back(ZLO_OUT | LO_IN | BUSY);
            exp_q.push_back(ZHI_OUT | HI_IN | DONE | BUSY);
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(GRB | R_OUT | Z_IN | BUSY | op_w);
            exp_q.push_back(ZLO_OUT | GRA | R_IN | DONE | BUSY);
        end else begin
            exp_q.push_back(ILLEGAL | BUSY);
        end
    endtask

    // Every cycle: compare against the model (idle when nothing is queued)
    // and confirm at most one bus driver is active.
    always @(negedge clock) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 27'd0;
        check("strobes", {5'd0, observe()}, {5'd0, exp_w});
        check("one_driver", 32'($countones({pc_out, zlo_out, zhi_out, mdr_out, r_out}) <= 1), 32'd1);
        if (pc_in) pc_in_cnt++;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("queue_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic run_instr(input string name, input logic [31:0] i, input int exp_lat,
                             input int low, input bit poke);
        int lat, w;
        wait_idle();
`ifdef SEQ_MEM_WAIT_EN
        w = low;
`else
        w = 0;
`endif
        ir = i;
        start = 1'b1;
        pc_in_cnt = 0;
        if (low > 0) mem_ready = 1'b0;
        exp_q.push_back(27'd0);
        model_instr(i, w);
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        while (!(done || illegal) && lat < 40) begin
            if (poke) start = (lat == 2);
            @(posedge clock); #1;
            lat++;
            if (lat == 2 + low) mem_ready = 1'b1;
        end
        start = 1'b0;
        mem_ready = 1'b1;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (low > 0) check({name, "_pc_in_once"}, 32'(pc_in_cnt), 32'd1);
        @(posedge clock); #1;
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear = 1'b0;
        start = 1'b0;
        mem_ready = 1'b1;
        ir = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {5'd0, observe()}, 32'd0);
        clear = 1'b1;
        @(posedge clock); #1;

        run_instr("add", IR_ADD, 6, 0, 1'b0);
        run_instr("mul", IR_MUL, 7, 0, 1'b1);
        run_instr("not", IR_NOT, 5, 0, 1'b0);
        run_instr("ill31", IR_ILL, 4, 0, 1'b0);
        run_instr("shl", IR_SHL, 6, 0, 1'b0);
        run_instr("div", IR_DIV, 7, 0, 1'b0);
        run_instr("neg", IR_NEG, 5, 0, 1'b1);
`ifdef SEQ_MEM_WAIT_EN
        run_instr("add_wait", IR_ADD, 9, 3, 1'b0);
`else
        run_instr("add_wait", IR_ADD, 6, 3, 1'b0);
`endif

        // Clear during T4 of add with start held, then a back-to-back pair.
        wait_idle();
        ir = IR_ADD;
        start = 1'b1;
        exp_q.push_back(27'd0);
        model_instr(IR_ADD, 0);
        repeat (5) @(posedge clock);
        #1;
        check("t4_alu_op", {27'd0, alu_op}, 32'd3);
        check("t4_grc", {31'd0, grc}, 32'd1);
        clear = 1'b0;
        exp_q.delete();
        exp_q.push_back(27'd0);
        exp_q.push_back(27'd0);
        #1;
        check("clear_async", {5'd0, observe()}, 32'd0);
        @(posedge clock); #1;
        clear = 1'b1;
        model_instr(IR_ADD, 0);
        model_instr(IR_ADD, 0);
        repeat (7) @(posedge clock);
        #1;
        check("b2b_second_t0", {31'd0, pc_out}, 32'd1);
        start = 1'b0;
        wait_idle();
        @(posedge clock); #1;
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
